// File: rtl/output_mixer.sv
// Output mixer around the SVF: filter-input sum, direct/filter mix and master volume.
// One shared sequencer walks voices, filter taps and volume bits, then registers the clipped results.
module output_mixer #(
  parameter int unsigned ACC_W = 19,
  parameter int unsigned VOL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clkEn,
  input  logic signed [15:0]  iVoice0,
  input  logic signed [15:0]  iVoice1,
  input  logic signed [15:0]  iVoice2,
  input  logic signed [15:0]  iLP,
  input  logic signed [15:0]  iBP,
  input  logic signed [15:0]  iHP,
  input  logic                iWE,
  input  logic [4:0]          iAddr,
  input  logic [7:0]          iData,
  output logic signed [15:0]  oFiltIn,
  output logic signed [15:0]  oOut,
  output logic                oValid
);

  localparam int unsigned SMP_W  = 16;
  localparam int unsigned ACCV_W = ACC_W + VOL_W;
  localparam int unsigned IDX_W  = (VOL_W > 4) ? $clog2(VOL_W) : 2;

  localparam logic signed [ACCV_W-1:0] C_MAX = ACCV_W'(32767);
  localparam logic signed [ACCV_W-1:0] C_MIN = ACCV_W'(-32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VOICE,
    S_FILT,
    S_VOL,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;

  logic [2:0]         r_route;
  logic [3:0]         r_mode;
  logic [VOL_W-1:0]   r_vol;

  logic [2:0]         r_route_s;
  logic [3:0]         r_mode_s;
  logic [VOL_W-1:0]   r_vol_s;

  logic signed [SMP_W-1:0] r_v0, r_v1, r_v2, r_lp, r_bp, r_hp;

  logic signed [ACC_W-1:0]  r_acc_f;
  logic signed [ACC_W-1:0]  r_acc_d;
  logic signed [ACCV_W-1:0] r_acc_v;

  logic signed [SMP_W-1:0]  w_v_term;
  logic                     w_v_route;
  logic                     w_v_mute;
  logic signed [SMP_W-1:0]  w_f_term;
  logic                     w_f_en;
  logic signed [ACCV_W-1:0] w_vol_term;

  function automatic logic signed [SMP_W-1:0] clip16(input logic signed [ACCV_W-1:0] x);
    if (x > C_MAX)      return 16'sh7fff;
    else if (x < C_MIN) return 16'sh8000;
    else                return x[SMP_W-1:0];
  endfunction

  // Control register file; writes land at any time, a pass only sees its snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_route <= '0;
      r_mode  <= '0;
      r_vol   <= '0;
    end else if (iWE) begin
      case (iAddr)
        5'h17: r_route <= iData[2:0];
        5'h18: begin
          r_mode <= iData[7:4];
          r_vol  <= iData[VOL_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and step index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (clkEn) begin
          w_state_nxt = S_VOICE;
          w_idx_nxt   = '0;
        end
      end
      S_VOICE: begin
        if (r_idx == IDX_W'(2)) begin
          w_state_nxt = S_FILT;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_FILT: begin
        if (r_idx == IDX_W'(2)) begin
          w_state_nxt = S_VOL;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_VOL: begin
        if (r_idx == IDX_W'(VOL_W - 1)) begin
          w_state_nxt = S_DONE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand selection for the current step.
  always_comb begin
    w_v_term  = r_v2;
    w_v_route = r_route_s[2];
    w_v_mute  = r_mode_s[3];
    w_f_term  = r_hp;
    w_f_en    = r_mode_s[2];
    case (r_idx)
      IDX_W'(0): begin
        w_v_term  = r_v0;
        w_v_route = r_route_s[0];
        w_v_mute  = 1'b0;
        w_f_term  = r_lp;
        w_f_en    = r_mode_s[0];
      end
      IDX_W'(1): begin
        w_v_term  = r_v1;
        w_v_route = r_route_s[1];
        w_v_mute  = 1'b0;
        w_f_term  = r_bp;
        w_f_en    = r_mode_s[1];
      end
      default: ;
    endcase
  end

  assign w_vol_term = ACCV_W'(r_acc_d) <<< r_idx;

  // Shared accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_route_s <= '0;
      r_mode_s  <= '0;
      r_vol_s   <= '0;
      r_v0      <= '0;
      r_v1      <= '0;
      r_v2      <= '0;
      r_lp      <= '0;
      r_bp      <= '0;
      r_hp      <= '0;
      r_acc_f   <= '0;
      r_acc_d   <= '0;
      r_acc_v   <= '0;
      oFiltIn   <= '0;
      oOut      <= '0;
      oValid    <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clkEn) begin
            r_route_s <= r_route;
            r_mode_s  <= r_mode;
            r_vol_s   <= r_vol;
            r_v0      <= iVoice0;
            r_v1      <= iVoice1;
            r_v2      <= iVoice2;
            r_lp      <= iLP;
            r_bp      <= iBP;
            r_hp      <= iHP;
            r_acc_f   <= '0;
            r_acc_d   <= '0;
            r_acc_v   <= '0;
          end
        end
        S_VOICE: begin
          // A filter-routed voice bypasses the direct-path mute.
          if (w_v_route)     r_acc_f <= r_acc_f + ACC_W'(w_v_term);
          else if (!w_v_mute) r_acc_d <= r_acc_d + ACC_W'(w_v_term);
        end
        S_FILT: begin
          if (w_f_en) r_acc_d <= r_acc_d + ACC_W'(w_f_term);
        end
        S_VOL: begin
          if (r_vol_s[r_idx]) r_acc_v <= r_acc_v + w_vol_term;
        end
        S_DONE: begin
          oFiltIn <= clip16(ACCV_W'(r_acc_f));
          oOut    <= clip16(r_acc_v >>> VOL_W);
          oValid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_mixer.sv
// Bench for output_mixer: directed vector table, corner sequences and a randomized model check.
module tb_output_mixer;

  logic clk = 1'b0;
  logic rst, clkEn, iWE;
  logic [4:0] iAddr;
  logic [7:0] iData;
  logic signed [15:0] iVoice0, iVoice1, iVoice2, iLP, iBP, iHP;
  logic signed [15:0] oFiltIn, oOut;
  logic oValid;

  int n_checks = 0;
  int n_pass   = 0;

  output_mixer dut (
    .clk(clk), .rst(rst), .clkEn(clkEn),
    .iVoice0(iVoice0), .iVoice1(iVoice1), .iVoice2(iVoice2),
    .iLP(iLP), .iBP(iBP), .iHP(iHP),
    .iWE(iWE), .iAddr(iAddr), .iData(iData),
    .oFiltIn(oFiltIn), .oOut(oOut), .oValid(oValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] route;
    logic [3:0] mode;
    logic [3:0] vol;
    int v0, v1, v2, lp, bp, hp;
    int ef, eo;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int clip16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Mix rules from first principles: integer sums, gain vol/16 rounded toward minus infinity.
  function automatic void model(input logic [2:0] route, input logic [3:0] mode, input logic [3:0] vol,
                                input int v0, input int v1, input int v2,
                                input int lp, input int bp, input int hp,
                                output int ef, output int eo);
    int v[3];
    int f, d, prod;
    v[0] = v0; v[1] = v1; v[2] = v2;
    f = 0; d = 0;
    for (int k = 0; k < 3; k++) begin
      if (route[k]) f += v[k];
      else if (!(k == 2 && mode[3])) d += v[k];
    end
    if (mode[0]) d += lp;
    if (mode[1]) d += bp;
    if (mode[2]) d += hp;
    prod = d * int'(vol);
    eo = clip16((prod - (((prod % 16) + 16) % 16)) / 16);
    ef = clip16(f);
  endfunction

  task automatic set_regs(input logic [2:0] route, input logic [3:0] mode, input logic [3:0] vol);
    @(negedge clk);
    iWE = 1'b1; iAddr = 5'h17; iData = {5'b0, route};
    @(negedge clk);
    iAddr = 5'h18; iData = {mode, vol};
    @(negedge clk);
    iAddr = 5'h08; iData = 8'hFF;
    @(negedge clk);
    iAddr = 5'h07; iData = 8'hFF;
    @(negedge clk);
    iWE = 1'b0;
  endtask

  task automatic set_audio(input int v0, input int v1, input int v2,
                           input int lp, input int bp, input int hp);
    iVoice0 = 16'(v0); iVoice1 = 16'(v1); iVoice2 = 16'(v2);
    iLP = 16'(lp); iBP = 16'(bp); iHP = 16'(hp);
  endtask

  // Pulse clkEn, then watch 24 edges; optional register write, extra clkEn and reset at given edges.
  task automatic run_pass(input int wr_at, input logic [7:0] wr_data, input int en_at, input int rst_at,
                          output int lat, output int pulses);
    lat = -1; pulses = 0;
    @(negedge clk);
    clkEn = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      clkEn = 1'b0; iWE = 1'b0; rst = 1'b0;
      if (oValid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (k == wr_at) begin iWE = 1'b1; iAddr = 5'h18; iData = wr_data; end
      if (k == en_at) clkEn = 1'b1;
      if (k == rst_at) rst = 1'b1;
    end
  endtask

  vec_t vecs[11];

  initial begin
    int lat, pulses, ef, eo;
    logic [2:0] r; logic [3:0] m, vl;
    int a[6];

    vecs[0]  = '{3'd0, 4'h0, 4'd15, 1000, 2000, 3000, 0, 0, 0, 0, 5625};
    vecs[1]  = '{3'd5, 4'h1, 4'd8, 100, 200, 300, -400, 0, 0, 400, -100};
    vecs[2]  = '{3'd0, 4'h8, 4'd15, 0, 0, 16000, 0, 0, 0, 0, 0};
    vecs[3]  = '{3'd4, 4'h8, 4'd15, 0, 0, 16000, 0, 0, 0, 16000, 0};
    vecs[4]  = '{3'd0, 4'h0, 4'd15, 32767, 32767, 32767, 32767, 32767, 32767, 0, 32767};
    vecs[5]  = '{3'd0, 4'h0, 4'd15, -32768, -32768, -32768, -32768, -32768, -32768, 0, -32768};
    vecs[6]  = '{3'd7, 4'h0, 4'd15, 32767, 32767, 32767, 0, 0, 0, 32767, 0};
    vecs[7]  = '{3'd7, 4'h0, 4'd15, -32768, -32768, -32768, 0, 0, 0, -32768, 0};
    vecs[8]  = '{3'd0, 4'h7, 4'd0, -5000, -5000, -5000, -7000, -7000, -7000, 0, 0};
    vecs[9]  = '{3'd0, 4'h2, 4'd1, 0, 0, 0, 0, -17, 0, 0, -2};
    vecs[10] = '{3'd2, 4'hF, 4'd4, 100, 200, 300, 10, 20, 30, 200, 40};

    rst = 1'b1; clkEn = 1'b0; iWE = 1'b0; iAddr = '0; iData = '0;
    set_audio(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_oOut", int'(oOut), 0);
    check("reset_oFiltIn", int'(oFiltIn), 0);
    check("reset_oValid", int'(oValid), 0);

    // Registers come out of reset at zero: route 0, vol 0 gives silence.
    set_audio(1000, 2000, 3000, 500, 500, 500);
    run_pass(-1, 8'h00, -1, -1, lat, pulses);
    check("rstregs_lat", lat, 11);
    check("rstregs_out", int'(oOut), 0);
    check("rstregs_filt", int'(oFiltIn), 0);

    for (int i = 0; i < 11; i++) begin
      set_regs(vecs[i].route, vecs[i].mode, vecs[i].vol);
      set_audio(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].lp, vecs[i].bp, vecs[i].hp);
      run_pass(-1, 8'h00, -1, -1, lat, pulses);
      check($sformatf("vec%0d_lat", i), lat, 11);
      check($sformatf("vec%0d_pulses", i), pulses, 1);
      check($sformatf("vec%0d_filt", i), int'(oFiltIn), vecs[i].ef);
      check($sformatf("vec%0d_out", i), int'(oOut), vecs[i].eo);
    end

    // Volume write right after clkEn and a mid-pass clkEn: old volume used, no queued pass.
    set_regs(3'd0, 4'h0, 4'd15);
    set_audio(1000, 2000, 3000, 0, 0, 0);
    run_pass(0, 8'h00, 4, -1, lat, pulses);
    check("midwr_lat", lat, 11);
    check("midwr_pulses", pulses, 1);
    check("midwr_out_hold", int'(oOut), 5625);
    run_pass(-1, 8'h00, -1, -1, lat, pulses);
    check("vol0_lat", lat, 11);
    check("vol0_out", int'(oOut), 0);

    // Reset during the volume phase aborts the pass.
    set_regs(3'd1, 4'h0, 4'd15);
    set_audio(1000, 2000, 3000, 0, 0, 0);
    run_pass(-1, 8'h00, -1, -1, lat, pulses);
    check("prerst_out", int'(oOut), 4687);
    check("prerst_filt", int'(oFiltIn), 1000);
    run_pass(-1, 8'h00, -1, 8, lat, pulses);
    check("rstmid_pulses", pulses, 0);
    check("rstmid_out", int'(oOut), 0);
    check("rstmid_filt", int'(oFiltIn), 0);
    set_regs(3'd1, 4'h0, 4'd15);
    run_pass(-1, 8'h00, -1, -1, lat, pulses);
    check("postrst_lat", lat, 11);
    check("postrst_out", int'(oOut), 4687);
    check("postrst_filt", int'(oFiltIn), 1000);

    // Randomized passes against the reference model.
    for (int i = 0; i < 40; i++) begin
      r = 3'($urandom_range(0, 7));
      m = 4'($urandom_range(0, 15));
      vl = 4'($urandom_range(0, 15));
      for (int j = 0; j < 6; j++) a[j] = int'($urandom_range(0, 65535)) - 32768;
      model(r, m, vl, a[0], a[1], a[2], a[3], a[4], a[5], ef, eo);
      set_regs(r, m, vl);
      set_audio(a[0], a[1], a[2], a[3], a[4], a[5]);
      run_pass(-1, 8'h00, -1, -1, lat, pulses);
      check($sformatf("rnd%0d_lat", i), lat, 11);
      check($sformatf("rnd%0d_filt", i), int'(oFiltIn), ef);
      check($sformatf("rnd%0d_out", i), int'(oOut), eo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
